// File: rtl/cola_vend_ctrl.sv
// Cola vending controller: coin credit, dispense handshake, change/refund.
// Optional COLA_DISP_TIMEOUT_EN adds a dispenser ack timeout with sticky po_fault.
module cola_vend_ctrl #(
  parameter int PRICE        = 5,
  parameter int CW           = 4,
  parameter int DISP_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pi_money_half,
  input  logic          pi_money_one,
  input  logic          pi_cancel,
  input  logic          disp_ack,
  output logic          po_cola,
  output logic          po_change,
  output logic          po_coin_reject,
  output logic          po_busy,
  output logic [CW-1:0] po_credit,
  output logic          po_fault
);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    COLLECT  = 5'b00010,
    DISPENSE = 5'b00100,
    CHANGE   = 5'b01000,
    REFUND   = 5'b10000
  } state_t;

  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

  state_t        state, state_nx;
  logic [CW-1:0] credit, credit_nx;
  logic [CW-1:0] chg, chg_nx;
  logic          phase, phase_nx;
  logic          cola_nx;
  logic          change_nx;
  logic          reject_nx;
  logic          busy_nx;
  logic [1:0]    v;
  logic [CW:0]   sum;

`ifdef COLA_DISP_TIMEOUT_EN
  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  logic [TW-1:0] tmr, tmr_nx;
  logic          fault_nx;
`endif

  // {one, half} is already the coin value in half-units
  assign v   = {pi_money_one, pi_money_half};
  assign sum = {1'b0, credit} + (CW+1)'(v);

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    chg_nx    = chg;
    phase_nx  = phase;
    cola_nx   = 1'b0;
    change_nx = 1'b0;
    reject_nx = 1'b0;
`ifdef COLA_DISP_TIMEOUT_EN
    tmr_nx    = '0;
    fault_nx  = po_fault;
`endif
    unique case (state)
      IDLE, COLLECT: begin
        phase_nx = 1'b0;
        if (sum >= PRICE_W) begin
          state_nx  = DISPENSE;
          chg_nx    = CW'(sum - PRICE_W);
          credit_nx = '0;
        end else if (sum != '0) begin
          if (pi_cancel) begin
            state_nx  = REFUND;
            chg_nx    = CW'(sum);
            credit_nx = '0;
          end else begin
            state_nx  = COLLECT;
            credit_nx = CW'(sum);
          end
        end else begin
          state_nx = IDLE;
        end
      end
      DISPENSE: begin
        reject_nx = |v;
        phase_nx  = 1'b0;
`ifdef COLA_DISP_TIMEOUT_EN
        tmr_nx    = tmr + TW'(1);
`endif
        if (disp_ack) begin
          state_nx = (chg != '0) ? CHANGE : IDLE;
`ifdef COLA_DISP_TIMEOUT_EN
        end else if (tmr == TW'(DISP_TIMEOUT)) begin
          state_nx = REFUND;
          chg_nx   = CW'(PRICE) + chg;
          fault_nx = 1'b1;
`endif
        end else begin
          cola_nx = 1'b1;
        end
      end
      CHANGE, REFUND: begin
        reject_nx = |v;
        // alternate high/low; leave after the low half of the last pulse
        if (!phase && chg != '0) begin
          change_nx = 1'b1;
          chg_nx    = chg - CW'(1);
          phase_nx  = 1'b1;
        end else begin
          phase_nx = 1'b0;
          if (chg == '0) state_nx = IDLE;
        end
      end
      default: begin
        state_nx  = IDLE;
        credit_nx = '0;
        chg_nx    = '0;
        phase_nx  = 1'b0;
      end
    endcase
    busy_nx = (state_nx == DISPENSE) ||
              (state_nx == CHANGE) ||
              (state_nx == REFUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      credit         <= '0;
      chg            <= '0;
      phase          <= 1'b0;
      po_cola        <= 1'b0;
      po_change      <= 1'b0;
      po_coin_reject <= 1'b0;
      po_busy        <= 1'b0;
    end else begin
      state          <= state_nx;
      credit         <= credit_nx;
      chg            <= chg_nx;
      phase          <= phase_nx;
      po_cola        <= cola_nx;
      po_change      <= change_nx;
      po_coin_reject <= reject_nx;
      po_busy        <= busy_nx;
    end
  end

  assign po_credit = credit;

`ifdef COLA_DISP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      po_fault <= 1'b0;
    end else begin
      tmr      <= tmr_nx;
      po_fault <= fault_nx;
    end
  end
`else
  assign po_fault = 1'b0;
`endif

endmodule

// File: tb/tb_cola_vend_ctrl.sv
// Scoreboard bench for cola_vend_ctrl: expected output events are queued
// with their cycle; a negedge monitor pops and compares.
module tb_cola_vend_ctrl;

  localparam int PRICE = 5;
  localparam int CW    = 4;
  localparam int TO    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pi_money_half, pi_money_one, pi_cancel, disp_ack;
  logic          po_cola, po_change, po_coin_reject, po_busy, po_fault;
  logic [CW-1:0] po_credit;

  cola_vend_ctrl #(
    .PRICE(PRICE), .CW(CW), .DISP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pi_money_half(pi_money_half), .pi_money_one(pi_money_one),
    .pi_cancel(pi_cancel), .disp_ack(disp_ack),
    .po_cola(po_cola), .po_change(po_change),
    .po_coin_reject(po_coin_reject), .po_busy(po_busy),
    .po_credit(po_credit), .po_fault(po_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_RISE, EV_FALL, EV_FAULT, EV_CHG, EV_REJ} ev_k;
  typedef struct {
    ev_k k;
    int  at;
  } ev_t;

  ev_t expq[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_k k, input int at);
    ev_t e;
    e.k  = k;
    e.at = at;
    expq.push_back(e);
  endtask

  task automatic observe(input ev_k k);
    ev_t e;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, want none",
               k.name(), cyc);
    end else begin
      e = expq.pop_front();
      if (e.k != k || e.at != cyc) begin
        n_fail++;
        $display("FAIL event: got %s at cycle %0d, want %s at cycle %0d",
                 k.name(), cyc, e.k.name(), e.at);
      end
    end
  endtask

  logic cola_q  = 1'b0;
  logic fault_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (po_cola && !cola_q)   observe(EV_RISE);
      if (!po_cola && cola_q)   observe(EV_FALL);
      if (po_fault && !fault_q) observe(EV_FAULT);
      if (po_change)            observe(EV_CHG);
      if (po_coin_reject)       observe(EV_REJ);
    end
    cola_q  <= po_cola;
    fault_q <= po_fault;
  end

  task automatic tick(input logic h, input logic o, input logic c);
    @(negedge clk);
    pi_money_half = h;
    pi_money_one  = o;
    pi_cancel     = c;
    @(posedge clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    disp_ack = 1'b1;
    push(EV_FALL, cyc + 1);
    @(posedge clk);
    #1;
    disp_ack = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check(name, expq.size(), 0);
    expq.delete();
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, int'(po_busy), 0);
    check({name, "_credit"}, int'(po_credit), 0);
  endtask

  int e;
  int ea;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    disp_ack      = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cola", int'(po_cola), 0);
    check("rst_change", int'(po_change), 0);
    check("rst_reject", int'(po_coin_reject), 0);
    check("rst_busy", int'(po_busy), 0);
    check("rst_credit", int'(po_credit), 0);
    check("rst_fault", int'(po_fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // one, one, half: exact price
    tick(0, 1, 0);
    check("t1_credit2", int'(po_credit), 2);
    tick(0, 1, 0);
    check("t1_credit4", int'(po_credit), 4);
    tick(1, 0, 0);
    e = cyc;
    push(EV_RISE, e + 1);
    check("t1_busy", int'(po_busy), 1);
    check("t1_credit0", int'(po_credit), 0);
    idle(3);
    ack_pulse();
    idle(2);
    check_idle("t1_end");
    drain("t1_drain");

    // credit 4 then one+half together: two change pulses
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 1, 0);
    e = cyc;
    push(EV_RISE, e + 1);
    idle(2);
    ack_pulse();
    ea = cyc;
    push(EV_CHG, ea + 1);
    push(EV_CHG, ea + 3);
    check("t2_busy_change", int'(po_busy), 1);
    idle(6);
    check_idle("t2_end");
    drain("t2_drain");

    // credit 3, cancel with half: refund 4
    tick(0, 1, 0);
    tick(1, 0, 0);
    check("t3_credit3", int'(po_credit), 3);
    tick(1, 0, 1);
    e = cyc;
    for (int i = 0; i < 4; i++) push(EV_CHG, e + 1 + 2 * i);
    check("t3_busy", int'(po_busy), 1);
    check("t3_credit0", int'(po_credit), 0);
    idle(10);
    check_idle("t3_end");
    drain("t3_drain");

    // coins during DISPENSE are bounced, cancel ignored
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    e = cyc;
    push(EV_RISE, e + 1);
    idle(1);
    tick(0, 1, 0);
    push(EV_REJ, cyc);
    check("t4_credit_busy", int'(po_credit), 0);
    idle(1);
    tick(1, 1, 1);
    push(EV_REJ, cyc);
    check("t4_credit_both", int'(po_credit), 0);
    check("t4_still_busy", int'(po_busy), 1);
    idle(2);
    ack_pulse();
    idle(2);
    check_idle("t4_end");
    drain("t4_drain");

    // ack already high on the first DISPENSE cycle
    @(negedge clk);
    disp_ack = 1'b1;
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    check("t5_busy_entry", int'(po_busy), 1);
    idle(1);
    check("t5_busy_after_ack", int'(po_busy), 0);
    disp_ack = 1'b0;
    idle(2);
    drain("t5_drain");

    // async reset mid-COLLECT discards credit
    tick(0, 1, 0);
    tick(1, 0, 0);
    check("t6_credit3", int'(po_credit), 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_credit", int'(po_credit), 0);
    check("t6_rst_busy", int'(po_busy), 0);
    check("t6_rst_cola", int'(po_cola), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 1);
    idle(8);
    check_idle("t6_end");
    drain("t6_drain");

`ifdef COLA_DISP_TIMEOUT_EN
    // no ack: timeout, fault, refund PRICE + 1
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    e = cyc;
    push(EV_RISE, e + 1);
    push(EV_FALL, e + 1 + TO);
    push(EV_FAULT, e + 1 + TO);
    for (int i = 0; i < PRICE + 1; i++)
      push(EV_CHG, e + 2 + TO + 2 * i);
    idle(30);
    check("t7_fault", int'(po_fault), 1);
    check_idle("t7_end");
    drain("t7_drain");
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    push(EV_RISE, cyc + 1);
    idle(2);
    ack_pulse();
    idle(2);
    check("t7_fault_sticky", int'(po_fault), 1);
    check_idle("t7_revend");
    drain("t7_revend_drain");
`else
    check("fault_tied", int'(po_fault), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cola_vend_ctrl.md
Name: cola_vend_ctrl

Overview:
- Top-level vending controller for the cola machine.
- Accepts 0.5 and 1.0 coin pulses and accumulates credit in half-units against a programmable price.
- Sequences an external dispenser through a req/ack handshake, then pays change or refunds as serial coin-hopper pulses.
- Rejects coins while busy.

Parameters:
- PRICE, 5, price in half-units (5 = 2.5); legal range 1 to 2^CW-4.
- CW, 4, credit/change counter width in bits.
- DISP_TIMEOUT, 255, ack-wait limit in clk cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pi_money_half  in  1  one-cycle pulse per 0.5 coin inserted.
- pi_money_one  in  1  one-cycle pulse per 1.0 coin inserted.
- pi_cancel  in  1  one-cycle pulse, refund request.
- disp_ack  in  1  dispenser done; level, sampled on clk.
- po_cola  out  1  dispense request, held until ack.
- po_change  out  1  one pulse per half-unit returned.
- po_coin_reject  out  1  one-cycle pulse, coin bounced because controller busy.
- po_busy  out  1  high in any state other than IDLE/COLLECT.
- po_credit  out  CW  current credit in half-units.
- po_fault  out  1  dispenser timeout flag; tied 0 without the optional feature.

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, credit 0, change counter 0. Reset mid-operation discards credit and the pending dispense; no refund.
- States, one-hot encoded: IDLE, COLLECT, DISPENSE, CHANGE, REFUND.
- Coin value per cycle: v = 1*half + 2*one, range 0..3. Both coin pulses in the same cycle are both accepted (v = 3).
- IDLE/COLLECT, let s = credit + v:
  - s >= PRICE: go to DISPENSE; change = s - PRICE (0..2); credit cleared.
  - else if s > 0: credit <= s, state COLLECT.
  - else: stay in IDLE.
- Cancel in IDLE/COLLECT:
  - If s > 0 after adding that cycle's coins: go to REFUND with change = s, credit 0.
  - A cancel on the same cycle that reaches PRICE is ignored; the purchase wins.
  - Cancel with s = 0 is ignored.
- DISPENSE:
  - po_cola rises the cycle after entry and is held until disp_ack is sampled 1.
  - po_cola falls on the next cycle. Then go to CHANGE if change > 0, else IDLE.
  - disp_ack high on the first DISPENSE cycle still counts.
- CHANGE/REFUND:
  - po_change pattern is 1,0,1,0...: high one cycle, low one cycle, repeated, decrementing change on each high cycle.
  - Go to IDLE on the cycle after the last low cycle.
  - Exits only to IDLE.
- Busy behaviour: in DISPENSE/CHANGE/REFUND any coin pulse produces a po_coin_reject pulse 1 cycle later and leaves credit unchanged. Both coins in one busy cycle give a single reject pulse. Cancel is ignored.
- po_credit reflects the registered credit; 0 whenever busy.
- Minimum latency: 1.0 coin to po_cola high is 1 cycle after the paying coin is sampled (state register) plus 1 (output register).

Optional Feature:
- Macro: COLA_DISP_TIMEOUT_EN.
- Defined: a cycle counter runs in DISPENSE.
  - If disp_ack has not been seen after DISP_TIMEOUT cycles: drop po_cola, set po_fault (sticky until reset), go to REFUND with change = PRICE + pending change.
  - A fault does not block later vends.
- Undefined: no counter; DISPENSE waits indefinitely; po_fault constant 0.

Test Plan:
- PRICE=5: pulses one, one, half on separate cycles -> po_credit 2,4; po_cola high 2 cycles after the half pulse; ack after 3 cycles -> po_cola drops; po_change never pulses; return to IDLE.
- Credit 4, then one+half in the same cycle (s=7) -> dispense, ack, then po_change pulses exactly 2 times, each 1 cycle high, 1 cycle apart; final credit 0.
- Credit 3, pi_cancel together with pi_money_half -> REFUND, 4 po_change pulses, no po_cola.
- During DISPENSE (ack held low), pulse pi_money_one -> po_coin_reject one pulse, po_credit stays 0; after ack, credit still 0.
- Credit 3, assert rst_n low mid-COLLECT -> all outputs 0 immediately (async); after release, a cancel produces no change pulses.
- COLA_DISP_TIMEOUT_EN, DISP_TIMEOUT=10, credit 6 (change 1), no ack -> po_cola high for 10 cycles then low, po_fault 1, 6 po_change pulses, IDLE.
